ring_gateway_wrr_arbiter: RTL
=============================

Name: ring_gateway_wrr_arbiter

Overview:
Packet-granular weighted round-robin arbiter that shares the gateway's ring-0 output buffer between three flit sources: forwarded ring traffic, local injection and external injection.
It holds a grant for a whole packet, so packets never interleave. Each source may send up to its configured quota of consecutive packets before the grant rotates.
It drops in where the gateway's ring-0 multiplexer sits, between the demux forward path, the local/ext inputs and the ring-0 dii_buffer. It also exposes per-source packet statistics.

Parameters:
WEIGHT_WIDTH, 4, width of each per-source packet quota input.
CNT_WIDTH, 16, width of each saturating per-source packet counter.

Ports:
clk  input  1  clock.
rst  input  1  reset; asynchronous, active-high.
in_ring  input  dii_flit  forwarded ring flits (source 0).
in_ring_ready  output  1  ready for in_ring.
in_local  input  dii_flit  local injection flits (source 1).
in_local_ready  output  1  ready for in_local.
in_ext  input  dii_flit  external injection flits (source 2).
in_ext_ready  output  1  ready for in_ext.
out_mux  output  dii_flit  arbitrated flit stream to the ring-0 buffer.
out_mux_ready  input  1  downstream ready.
weight_ring, weight_local, weight_ext  input  WEIGHT_WIDTH each  packet quota per grant; 0 is treated as 1.
cnt_clear  input  1  synchronous clear of all packet counters.
cnt_ring, cnt_local, cnt_ext  output  CNT_WIDTH each  packets forwarded per source.
grant  output  3  one-hot current grant {ext,local,ring}; 0 when idle.
busy  output  1  high when any grant is held.

Behaviour:
- Transfer: a flit moves when valid and ready are both high in the same cycle. A packet ends on a transfer with last=1.
- States:
  - IDLE: grant=0; all in_*_ready=0; out_mux.valid=0.
  - GRANT: out_mux equals the granted input, field for field. The granted in_*_ready equals out_mux_ready; the other readys are 0.
  - In GRANT with grant=0, out_mux.valid=0.
- Arbitration in IDLE:
  - Sample the valid bits. Search from rr_ptr upward, modulo 3, and pick the first valid source.
  - Next cycle: state=GRANT, grant=one-hot of the pick, quota=max(weight_of_pick,1).
  - Weights are sampled only at this point.
  - If nothing is valid, stay in IDLE.
  - Grant latency is 1 cycle: the first flit can transfer the cycle after the request is first seen in IDLE.
- in_pkt flag: set by a transfer with last=0, cleared by a transfer with last=1.
- End of packet (transfer with last=1): quota decrements and the source's packet counter increments.
- Release from GRANT happens only at a packet boundary (in_pkt=0 after the current cycle), to IDLE, with rr_ptr set to granted index + 1 mod 3:
  - (a) quota reaches 0 on this packet end, or
  - (b) the granted input's valid=0 at the boundary while some other input's valid=1.
  - If neither holds, stay in GRANT. A lone requester keeps its grant, reloaded with no bubble: when quota reaches 0 and no other source is valid, quota reloads from the weight and the grant is held.
- Mid-packet: never release, even if the granted input drops valid or the other inputs request.
- A single-flit packet (last=1 on its first flit) is a complete packet.
- Counters:
  - Increment by 1 per packet end of their source; saturate at all-ones with no wrap.
  - cnt_clear zeroes all three next cycle and wins over a same-cycle increment.
- busy = (state==GRANT).
- Reset (asynchronous, also mid-packet):
  - state=IDLE, grant=0, rr_ptr=0 (ring), quota=0, in_pkt=0, counters=0.
  - All readys=0; out_mux.valid=0, out_mux.last=0, out_mux.data=0.
  - No partial packet is completed after reset.
- out_mux.data is passed through unregistered. Only the control state is registered, and there is no combinational path from out_mux_ready to grant.

Test Plan:
1. Reset, then only in_local sends a 3-flit packet (last on flit 3) with out_mux_ready=1 → grant=3'b010 one cycle after valid; 3 transfers in consecutive cycles; cnt_local=1; grant held while local stays sole requester.
2. All three valid continuously with 2-flit packets, weights=1 → packet order ring, local, ext, ring…; 1-cycle IDLE bubble between packets; after 6 packets each counter=2.
3. weight_ring=3, weight_local=1, weight_ext=0, all always valid → repeating packet order ring, ring, ring, local, ext.
4. Mid-packet: grant ring; after flit 1 (last=0), ring drops valid for 4 cycles while local is valid → grant stays 3'b001; local_ready=0; ring's flit 2 (last=1) completes, then grant moves to local.
5. Backpressure: out_mux_ready toggles 1/0 every cycle during a 4-flit ext packet → exactly 4 transfers, ext_ready mirrors out_mux_ready, no flit dropped or duplicated.
6. Assert rst mid-packet (grant=local, in_pkt=1) → outputs zero immediately (async); after release, arbitration restarts from ring. Separately: preload cnt_ring=0xFFFF then send a packet → it stays 0xFFFF; cnt_clear coinciding with a packet end → 0.

Source files
------------

// File: rtl/ring_gateway_wrr_arbiter_if.sv
// Flit handshake bundle (dii_flit plus its ready) used on every arbiter port.
// The master drives valid/last/data and the slave drives ready.
interface ring_gateway_wrr_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  last;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/ring_gateway_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter for the gateway's ring-0 output buffer.
// Sources: 0 = forwarded ring, 1 = local injection, 2 = external injection.
module ring_gateway_wrr_arbiter #(
  parameter int WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  ring_gateway_wrr_arbiter_if.slave   in_ring,
  ring_gateway_wrr_arbiter_if.slave   in_local,
  ring_gateway_wrr_arbiter_if.slave   in_ext,
  ring_gateway_wrr_arbiter_if.master  out_mux,
  input  logic [WEIGHT_WIDTH-1:0]     weight_ring,
  input  logic [WEIGHT_WIDTH-1:0]     weight_local,
  input  logic [WEIGHT_WIDTH-1:0]     weight_ext,
  input  logic                        cnt_clear,
  output logic [CNT_WIDTH-1:0]        cnt_ring,
  output logic [CNT_WIDTH-1:0]        cnt_local,
  output logic [CNT_WIDTH-1:0]        cnt_ext,
  output logic [2:0]                  grant,
  output logic                        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              grant_q, grant_d;
  logic [1:0]              rrPtr_q, rrPtr_d;
  logic [WEIGHT_WIDTH-1:0] quota_q, quota_d;
  logic                    inPkt_q, inPkt_d;
  logic [CNT_WIDTH-1:0]    cnt_q [3];
  logic [CNT_WIDTH-1:0]    cnt_d [3];

  logic [2:0]              validVec, lastVec, readyVec;
  logic [DATA_WIDTH-1:0]   dataVec [3];
  logic [WEIGHT_WIDTH-1:0] weightVec [3];

  logic [1:0]              gIdx, pick, cand;
  logic                    found, gValid, gLast, xfer, pktEnd, othersValid, quotaOut;
  logic [DATA_WIDTH-1:0]   gData;
  logic                    outValid, outLast;
  logic [DATA_WIDTH-1:0]   outData;

  function automatic logic [WEIGHT_WIDTH-1:0] clampWeight(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  assign validVec     = {in_ext.valid, in_local.valid, in_ring.valid};
  assign lastVec      = {in_ext.last, in_local.last, in_ring.last};
  assign dataVec[0]   = in_ring.data;
  assign dataVec[1]   = in_local.data;
  assign dataVec[2]   = in_ext.data;
  assign weightVec[0] = weight_ring;
  assign weightVec[1] = weight_local;
  assign weightVec[2] = weight_ext;

  always_comb begin
    gIdx  = 2'd0;
    gData = '0;
    if (grant_q[1])      gIdx = 2'd1;
    else if (grant_q[2]) gIdx = 2'd2;
    gValid      = |(grant_q & validVec);
    gLast       = |(grant_q & lastVec);
    othersValid = |(validVec & ~grant_q);
    for (int s = 0; s < 3; s++) gData = gData | (dataVec[s] & {DATA_WIDTH{grant_q[s]}});
  end

  // Round-robin search starting at rrPtr_q, wrapping modulo 3.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cand = 2'((int'(rrPtr_q) + k) % 3);
      if (!found && validVec[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rrPtr_d  = rrPtr_q;
    quota_d  = quota_q;
    inPkt_d  = inPkt_q;
    readyVec = 3'b000;
    outValid = 1'b0;
    outLast  = 1'b0;
    outData  = '0;
    xfer     = 1'b0;
    pktEnd   = 1'b0;
    quotaOut = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = 3'b001 << pick;
          quota_d = clampWeight(weightVec[pick]);
        end
      end
      GRANT: begin
        if (grant_q == 3'b000) begin
          state_d = IDLE;
        end else begin
          outValid = gValid;
          outLast  = gLast;
          outData  = gData;
          readyVec = grant_q & {3{out_mux.ready}};
          xfer     = gValid & out_mux.ready;
          pktEnd   = xfer & gLast;
          quotaOut = pktEnd && (quota_q <= WEIGHT_WIDTH'(1));
          if (xfer) inPkt_d = ~gLast;
          if (pktEnd) quota_d = quota_q - WEIGHT_WIDTH'(1);
          // Releases are only considered on packet boundaries; a lone requester reloads instead.
          if (!inPkt_d) begin
            if (othersValid && (quotaOut || !gValid)) begin
              state_d = IDLE;
              grant_d = 3'b000;
              rrPtr_d = (gIdx == 2'd2) ? 2'd0 : gIdx + 2'd1;
            end else if (quotaOut) begin
              quota_d = clampWeight(weightVec[gIdx]);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      cnt_d[s] = cnt_q[s];
      if (cnt_clear)
        cnt_d[s] = '0;
      else if (pktEnd && grant_q[s] && (cnt_q[s] != {CNT_WIDTH{1'b1}}))
        cnt_d[s] = cnt_q[s] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      rrPtr_q <= 2'd0;
      quota_q <= '0;
      inPkt_q <= 1'b0;
      for (int s = 0; s < 3; s++) cnt_q[s] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
      quota_q <= quota_d;
      inPkt_q <= inPkt_d;
      for (int s = 0; s < 3; s++) cnt_q[s] <= cnt_d[s];
    end
  end

  assign in_ring.ready  = readyVec[0];
  assign in_local.ready = readyVec[1];
  assign in_ext.ready   = readyVec[2];
  assign out_mux.valid  = outValid;
  assign out_mux.last   = outLast;
  assign out_mux.data   = outData;
  assign cnt_ring       = cnt_q[0];
  assign cnt_local      = cnt_q[1];
  assign cnt_ext        = cnt_q[2];
  assign grant          = grant_q;
  assign busy           = (state_q == GRANT);

endmodule
